floor_request_sched: RTL and testbench
======================================

FLOOR_REQUEST_SCHED -- requirements
Module: floor_request_sched

Interface
REQ-001 The module SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter: DEB_CYCLES, 4, consecutive synchronized-high cycles required to accept a button press (range 1..255).
REQ-003 Parameter: TRAVEL_CYCLES, 8, cycles allotted per floor of travel after a request is issued (range 1..255).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: btn_g / btn_f / btn_s  input  1 each  raw asynchronous call buttons for ground, first and second floor.
REQ-007 Port: emerg_in  input  1  emergency request, level, asynchronous to nothing (already synchronous to clk).
REQ-008 Port: cur_floor  input  4  current floor from the elevator controller (0, 1, 2; values 3..15 SHALL be treated as 2).
REQ-009 Port: g_f / f_f / s_f  output  1 each  registered one-cycle floor-request pulses to the elevator controller.
REQ-010 Port: pending  output  3  registered latched requests {s,f,g} (bit0 = ground).
REQ-011 Port: busy  output  1  high in ISSUE, TRAVEL and LOCKED states.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 A button's debounced level SHALL go high when its synchronized level has been high for DEB_CYCLES consecutive cycles, and low on the first synchronized-low cycle.
REQ-014 The rising edge of a debounced level SHALL set the matching pending bit one cycle later; a button held high SHALL set it only once.
REQ-015 With DEB_CYCLES=4 and a clean raw press, the pending bit SHALL assert on the 7th rising clk edge after the raw input rises.
REQ-016 State machine SHALL have states IDLE, ISSUE, TRAVEL, LOCKED.
REQ-017 IDLE: if pending is nonzero, select the pending floor nearest cur_floor (tie -> lower floor), register it as target and its distance, clear its pending bit, go to ISSUE.
REQ-018 IDLE: if the selected target equals cur_floor, the pending bit SHALL be cleared, no pulse SHALL be issued, and the state SHALL remain IDLE.
REQ-019 ISSUE: exactly one of g_f/f_f/s_f SHALL be high for exactly one cycle; next state TRAVEL.
REQ-020 TRAVEL: count distance*TRAVEL_CYCLES cycles (distance 1 or 2), then return to IDLE; at most one pulse per TRAVEL period.
REQ-021 Button presses arriving in any state except LOCKED SHALL be latched into pending; a press for a floor already pending SHALL be absorbed.
REQ-022 A pending bit set in the same cycle IDLE clears the same floor SHALL remain set (set wins).
REQ-023 emerg_in high in any state SHALL, on the next edge, clear pending, force all pulses low and enter LOCKED; a pulse scheduled for that cycle SHALL be suppressed.
REQ-024 LOCKED SHALL be left only by reset; button presses in LOCKED SHALL be ignored.
REQ-025 The travel counter SHALL be wide enough for 2*TRAVEL_CYCLES with no wrap.

Reset
REQ-026 On reset: state IDLE, pending 3'b000, g_f/f_f/s_f 0, busy 0, synchronizers, debounce counters and travel counter 0.
REQ-027 Reset asserted mid-TRAVEL or mid-ISSUE SHALL abort with no pulse on the following cycle.

Configuration
REQ-028 Macro FLOOR_REQUEST_SCHED_DEBOUNCE_EN defined: debounce per REQ-013; undefined: debounced level equals the synchronized level, DEB_CYCLES is ignored, pending asserts on the 3rd edge after the raw rise.

Verification
REQ-029 Reset, cur_floor=0, btn_s held 20 cycles -> pending=3'b100 at edge 7, s_f single pulse next cycle, busy high for 1+16 cycles.
REQ-030 btn_s glitch high 2 cycles (DEBOUNCE_EN, DEB_CYCLES=4) -> pending stays 0, no pulse.
REQ-031 cur_floor=1, btn_g and btn_s pressed same cycle -> g_f issued first (tie -> lower), s_f only after 8-cycle TRAVEL completes.
REQ-032 cur_floor=2, btn_s pressed -> pending bit clears, no pulse, busy stays 0.
REQ-033 emerg_in asserted during TRAVEL with pending=3'b011 -> pending 0, LOCKED, no further pulses despite presses, until reset.
REQ-034 Macro undefined, btn_f pressed at cur_floor=0 -> pending[1] at edge 3, f_f pulse at edge 5.

Source files
------------

// File: rtl/floor_request_sched.sv
// floor_request_sched: debounced call buttons latched into pending requests, issued nearest-first as one-cycle floor pulses.
// Define FLOOR_REQUEST_SCHED_DEBOUNCE_EN to enable the DEB_CYCLES debounce filter.
module floor_request_sched #(
  parameter int DEB_CYCLES    = 4,
  parameter int TRAVEL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_g,
  input  logic       btn_f,
  input  logic       btn_s,
  input  logic       emerg_in,
  input  logic [3:0] cur_floor,
  output logic       g_f,
  output logic       f_f,
  output logic       s_f,
  output logic [2:0] pending,
  output logic       busy
);
  localparam int CW = $clog2(2 * TRAVEL_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, TRAVEL, LOCKED} state_t;
  state_t r_state, w_next;
  logic [2:0] w_btn, r_s1, r_s2, r_prev, w_deb, w_rise, w_clr, r_pend, r_pulse;
  logic [1:0] w_cur, w_sel, w_seld, r_tgt, r_dist;
  logic [CW-1:0] r_cnt, w_lim;

  function automatic logic [1:0] fdist(input logic [1:0] a, input logic [1:0] b);
    return a > b ? a - b : b - a;
  endfunction

  assign w_btn = {btn_s, btn_f, btn_g};
  assign w_cur = cur_floor > 4'd2 ? 2'd2 : cur_floor[1:0];
  assign w_rise = w_deb & ~r_prev & {3{r_state != LOCKED}};
  assign w_lim = r_dist == 2'd2 ? CW'(2 * TRAVEL_CYCLES - 1) : CW'(TRAVEL_CYCLES - 1);

`ifdef FLOOR_REQUEST_SCHED_DEBOUNCE_EN
  logic [7:0] r_dcnt [3];
  logic [2:0] r_deb;
  // Counter saturates at DEB_CYCLES-1 so a held button keeps its level high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dcnt <= '{default: '0};
      r_deb  <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        r_dcnt[k] <= !r_s2[k] ? 8'd0 : (r_dcnt[k] == 8'(DEB_CYCLES - 1) ? r_dcnt[k] : r_dcnt[k] + 8'd1);
        r_deb[k]  <= r_s2[k] && r_dcnt[k] >= 8'(DEB_CYCLES - 1);
      end
    end
  end
  assign w_deb = r_deb;
`else
  logic w_unused;
  assign w_unused = ^DEB_CYCLES;
  assign w_deb = r_s2;
`endif

  // Nearest pending floor; strict compare in ascending order keeps the lower floor on ties.
  always_comb begin
    w_sel  = '0;
    w_seld = 2'd3;
    for (int k = 0; k < 3; k++)
      if (r_pend[k] && fdist(2'(k), w_cur) < w_seld) begin
        w_sel  = 2'(k);
        w_seld = fdist(2'(k), w_cur);
      end
  end

  always_comb begin
    w_next = r_state;
    w_clr  = '0;
    case (r_state)
      IDLE: if (|r_pend) begin
        w_clr  = 3'b001 << w_sel;
        w_next = w_seld == 2'd0 ? IDLE : ISSUE;
      end
      ISSUE:   w_next = TRAVEL;
      TRAVEL:  w_next = r_cnt == w_lim ? IDLE : TRAVEL;
      default: w_next = LOCKED;
    endcase
    if (emerg_in) w_next = LOCKED;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_prev  <= '0;
      r_pend  <= '0;
      r_pulse <= '0;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_dist  <= '0;
    end else begin
      r_s1    <= w_btn;
      r_s2    <= r_s1;
      r_prev  <= w_deb;
      r_pend  <= emerg_in ? 3'b000 : (r_pend & ~w_clr) | w_rise;
      r_pulse <= (r_state == ISSUE && !emerg_in) ? 3'b001 << r_tgt : 3'b000;
      r_cnt   <= (r_state == TRAVEL && w_next == TRAVEL) ? r_cnt + CW'(1) : '0;
      if (r_state == IDLE && w_next == ISSUE) begin
        r_tgt  <= w_sel;
        r_dist <= w_seld;
      end
    end
  end

  assign {s_f, f_f, g_f} = r_pulse;
  assign pending = r_pend;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_floor_request_sched.sv
// tb_floor_request_sched: directed scenarios with a pulse scoreboard for floor_request_sched.
module tb_floor_request_sched;
  localparam int DEB = 4, TRV = 8;
`ifdef FLOOR_REQUEST_SCHED_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif
  logic clk = 0, reset = 1, btn_g = 0, btn_f = 0, btn_s = 0, emerg_in = 0;
  logic [3:0] cur_floor = 0;
  logic g_f, f_f, s_f, busy;
  logic [2:0] pending;
  int checks = 0, failures = 0;
  int t_g, t_s, t_f, nb;
  logic [2:0] sb[$];

  floor_request_sched #(.DEB_CYCLES(DEB), .TRAVEL_CYCLES(TRV)) dut (
    .clk(clk), .reset(reset), .btn_g(btn_g), .btn_f(btn_f), .btn_s(btn_s),
    .emerg_in(emerg_in), .cur_floor(cur_floor), .g_f(g_f), .f_f(f_f), .s_f(s_f),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk)
    if ({s_f, f_f, g_f} != 3'b000) begin
      if (sb.size() == 0) chk("unexpected_pulse", {29'd0, s_f, f_f, g_f}, 0);
      else chk("pulse_order", {29'd0, s_f, f_f, g_f}, {29'd0, sb.pop_front()});
    end

  initial begin
    repeat (3) step();
    reset = 0;
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {s_f, f_f, g_f}, 0);
    // second floor from ground, held long
    btn_s = 1;
    sb.push_back(3'b100);
    repeat (LAT - 1) step();
    chk("t1_pend_before", pending, 0);
    step();
    chk("t1_pend_edge", pending, 3'b100);
    step();
    chk("t1_issue_busy", busy, 1);
    chk("t1_pend_clr", pending, 0);
    step();
    chk("t1_s_pulse", {s_f, f_f, g_f}, 3'b100);
    nb = 2;
    repeat (30) begin
      step();
      if (busy) nb++;
    end
    chk("t1_busy_len", nb, 17);
    chk("t1_held_once", pending, 0);
    btn_s = 0;
    repeat (LAT + 2) step();
`ifdef FLOOR_REQUEST_SCHED_DEBOUNCE_EN
    btn_s = 1;
    step();
    step();
    btn_s = 0;
    repeat (12) step();
    chk("glitch_pend", pending, 0);
    chk("glitch_busy", busy, 0);
`endif
    // tie at floor 1: ground first, second after travel
    cur_floor = 1;
    btn_g = 1;
    btn_s = 1;
    sb.push_back(3'b001);
    sb.push_back(3'b100);
    t_g = 0;
    t_s = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == LAT) chk("t2_pend", pending, 3'b101);
      if (g_f) t_g = n;
      if (s_f) t_s = n;
      if (n == LAT + 1) begin
        btn_g = 0;
        btn_s = 0;
      end
    end
    chk("t2_g_time", t_g, LAT + 2);
    chk("t2_s_time", t_s, LAT + 12);
    // request for the current floor is dropped
    cur_floor = 2;
    btn_s = 1;
    nb = 0;
    for (int n = 1; n <= LAT + 6; n++) begin
      step();
      if (busy) nb++;
      if (n == LAT) chk("t3_pend_set", pending, 3'b100);
      if (n == LAT + 1) begin
        chk("t3_pend_clr", pending, 0);
        btn_s = 0;
      end
    end
    chk("t3_busy", nb, 0);
    // emergency during travel
    cur_floor = 0;
    btn_s = 1;
    sb.push_back(3'b100);
    repeat (LAT + 2) step();
    chk("t4_s_pulse", {s_f, f_f, g_f}, 3'b100);
    btn_s = 0;
    btn_g = 1;
    btn_f = 1;
    repeat (LAT) step();
    chk("t4_pend_011", pending, 3'b011);
    chk("t4_travel_busy", busy, 1);
    emerg_in = 1;
    step();
    emerg_in = 0;
    chk("t4_emerg_pend", pending, 0);
    chk("t4_emerg_busy", busy, 1);
    chk("t4_emerg_pulse", {s_f, f_f, g_f}, 0);
    btn_g = 0;
    btn_f = 0;
    repeat (LAT + 2) step();
    btn_g = 1;
    btn_f = 1;
    btn_s = 1;
    repeat (LAT + 10) step();
    chk("t4_lock_pend", pending, 0);
    chk("t4_lock_busy", busy, 1);
    btn_g = 0;
    btn_f = 0;
    btn_s = 0;
    reset = 1;
    step();
    reset = 0;
    chk("t4_unlock_busy", busy, 0);
    chk("t4_unlock_pend", pending, 0);
    // reset while in ISSUE aborts the pulse
    btn_f = 1;
    repeat (LAT + 1) step();
    chk("t5_issue_busy", busy, 1);
    reset = 1;
    btn_f = 0;
    step();
    reset = 0;
    chk("t5_abort_pulse", {s_f, f_f, g_f}, 0);
    chk("t5_abort_busy", busy, 0);
    step();
    chk("t5_abort_pulse2", {s_f, f_f, g_f}, 0);
    // first floor from ground: pending then pulse timing
    btn_f = 1;
    sb.push_back(3'b010);
    t_f = 0;
    for (int n = 1; n <= LAT + 4; n++) begin
      step();
      if (n == LAT) chk("t6_pend", pending, 3'b010);
      if (f_f) t_f = n;
    end
    btn_f = 0;
    chk("t6_f_time", t_f, LAT + 2);
    repeat (15) step();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
